// File: rtl/clk_en_divider.sv
// Multi-channel programmable clock-enable / divided-clock generator.
// Each channel counts 0..div, emitting a one-cycle tick at each wrap and either a
// toggling divided clock or a copy of the tick. Configuration is applied either
// immediately (restarting the channel) or deferred to the next wrap via a shadow.
module clk_en_divider #(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned CNT_WIDTH   = 29,
   parameter int unsigned DEFAULT_DIV = 3000000,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 i_clock,
   input  logic                 i_resetn,
   input  logic [NUM_CH-1:0]    i_run,
   input  logic                 i_cfg_we,
   input  logic [CH_W-1:0]      i_cfg_ch,
   input  logic [CNT_WIDTH-1:0] i_cfg_div,
   input  logic                 i_cfg_mode,
   input  logic                 i_cfg_sync,
   output logic [NUM_CH-1:0]    o_tick,
   output logic [NUM_CH-1:0]    o_div_out,
   output logic [NUM_CH-1:0]    o_pending
);

   localparam logic [CNT_WIDTH-1:0] ResetDiv = CNT_WIDTH'(DEFAULT_DIV);
   localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] r_cnt  [NUM_CH];
   logic [CNT_WIDTH-1:0] r_div  [NUM_CH];
   logic [CNT_WIDTH-1:0] r_sdiv [NUM_CH];
   logic [NUM_CH-1:0]    r_mode, r_smode, r_pending, r_tick, r_div_out;

   logic [CNT_WIDTH-1:0] w_cnt_nxt  [NUM_CH];
   logic [CNT_WIDTH-1:0] w_div_nxt  [NUM_CH];
   logic [CNT_WIDTH-1:0] w_sdiv_nxt [NUM_CH];
   logic [NUM_CH-1:0]    w_mode_nxt, w_smode_nxt, w_pending_nxt, w_tick_nxt, w_div_out_nxt;
   logic [NUM_CH-1:0]    w_sel, w_wrap;

   // Per-channel next-state: immediate write wins, then counting / deferred reload.
   always_comb begin
      w_cnt_nxt     = r_cnt;
      w_div_nxt     = r_div;
      w_sdiv_nxt    = r_sdiv;
      w_mode_nxt    = r_mode;
      w_smode_nxt   = r_smode;
      w_pending_nxt = r_pending;
      w_tick_nxt    = r_tick;
      w_div_out_nxt = r_div_out;
      w_sel         = '0;
      w_wrap        = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         // Out-of-range channel numbers never match, so such writes are dropped.
         w_sel[i]  = i_cfg_we && (int'(i_cfg_ch) == i);
         w_wrap[i] = (r_cnt[i] == r_div[i]);
         if (w_sel[i] && i_cfg_sync) begin
            w_div_nxt[i]     = i_cfg_div;
            w_mode_nxt[i]    = i_cfg_mode;
            w_cnt_nxt[i]     = '0;
            w_tick_nxt[i]    = 1'b0;
            w_div_out_nxt[i] = 1'b0;
            w_pending_nxt[i] = 1'b0;
         end else begin
            if (w_sel[i]) begin
               w_sdiv_nxt[i]    = i_cfg_div;
               w_smode_nxt[i]   = i_cfg_mode;
               w_pending_nxt[i] = 1'b1;
            end
            if (i_run[i] && w_wrap[i]) begin
               w_cnt_nxt[i]     = '0;
               w_tick_nxt[i]    = 1'b1;
               w_div_out_nxt[i] = r_mode[i] ? 1'b1 : ~r_div_out[i];
               // Reloads happen only here, with cnt returning to 0: no runt periods.
               if (w_sel[i]) begin
                  w_div_nxt[i]     = i_cfg_div;
                  w_mode_nxt[i]    = i_cfg_mode;
                  w_pending_nxt[i] = 1'b0;
               end else if (r_pending[i]) begin
                  w_div_nxt[i]     = r_sdiv[i];
                  w_mode_nxt[i]    = r_smode[i];
                  w_pending_nxt[i] = 1'b0;
               end
            end else begin
               if (i_run[i]) begin
                  w_cnt_nxt[i] = r_cnt[i] + CntOne;
               end
               w_tick_nxt[i] = 1'b0;
               if (r_mode[i]) begin
                  w_div_out_nxt[i] = 1'b0;
               end
            end
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i]  <= '0;
            r_div[i]  <= ResetDiv;
            r_sdiv[i] <= ResetDiv;
         end
         r_mode    <= '0;
         r_smode   <= '0;
         r_pending <= '0;
         r_tick    <= '0;
         r_div_out <= '0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_div     <= w_div_nxt;
         r_sdiv    <= w_sdiv_nxt;
         r_mode    <= w_mode_nxt;
         r_smode   <= w_smode_nxt;
         r_pending <= w_pending_nxt;
         r_tick    <= w_tick_nxt;
         r_div_out <= w_div_out_nxt;
      end
   end

   assign o_tick    = r_tick;
   assign o_div_out = r_div_out;
   assign o_pending = r_pending;

endmodule
